// File: rtl/pe_vector_feeder_pkg.sv
// ---------------------------------------------------------------------------
// pe_feeder_pkg
// Shared definitions for the PE vector feeder.
//   state_t      : sequencing FSM states
//   CTRL_FIRST   : bit of pe_ctrl marking the first element of a vector
//   CTRL_LAST    : bit of pe_ctrl marking the last element of a vector
//   FIFO_DEPTH   : result FIFO depth, which is also the credit pool for rows
//   credit_ok()  : may a new row start, given FIFO occupancy and rows in flight
// ---------------------------------------------------------------------------
package pe_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CTRL_FIRST = 0;
    localparam int CTRL_LAST  = 1;
    localparam int FIFO_DEPTH = 2;

    // A row may start only when every result already queued or still being
    // computed has a FIFO slot reserved, so a new row never overruns the FIFO.
    function automatic logic credit_ok(input logic [1:0] fifo_count,
                                       input logic [1:0] rows_in_flight);
        return (3'(fifo_count) + 3'(rows_in_flight)) < 3'(FIFO_DEPTH);
    endfunction

endpackage

// File: rtl/pe_vector_feeder_result_fifo.sv
// ---------------------------------------------------------------------------
// pe_result_fifo
// Two-entry FIFO holding inner-product results together with their
// output-neuron index.
//   clk, rst     : clock, asynchronous active-high reset
//   push         : write push_data/push_idx this cycle
//   push_data    : result to store
//   push_idx     : output-neuron index of the result
//   pop_valid    : head entry available
//   pop_ready    : consumer accepts the head entry
//   pop_data     : head result (held while pop_valid && !pop_ready)
//   pop_idx      : head index
//   count        : current occupancy, used for row credits
// ---------------------------------------------------------------------------
module pe_result_fifo
    import pe_feeder_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [ACC_W-1:0] push_data,
    input  logic [IDX_W-1:0] push_idx,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [ACC_W-1:0] pop_data,
    output logic [IDX_W-1:0] pop_idx,
    output logic [1:0]       count
);

    logic [ACC_W-1:0] data_q [FIFO_DEPTH];
    logic [ACC_W-1:0] data_d [FIFO_DEPTH];
    logic [IDX_W-1:0] idx_q  [FIFO_DEPTH];
    logic [IDX_W-1:0] idx_d  [FIFO_DEPTH];

    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q,  count_d;

    logic do_pop;
    logic do_push;

    assign do_pop  = (count_q != 2'd0) && pop_ready;
    // A push into a full FIFO is accepted only when the head leaves in the
    // same cycle; the occupancy then stays the same.
    assign do_push = push && ((count_q < 2'(FIFO_DEPTH)) || do_pop);

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_comb begin
                data_d[gi] = data_q[gi];
                idx_d[gi]  = idx_q[gi];
                if (do_push && (wr_ptr_q == 1'(gi))) begin
                    data_d[gi] = push_data;
                    idx_d[gi]  = push_idx;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q[gi] <= '0;
                    idx_q[gi]  <= '0;
                end else begin
                    data_q[gi] <= data_d[gi];
                    idx_q[gi]  <= idx_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_valid = (count_q != 2'd0);
    assign pop_data  = data_q[rd_ptr_q];
    assign pop_idx   = idx_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/pe_vector_feeder.sv
// ---------------------------------------------------------------------------
// pe_vector_feeder
// Streams one neuron vector against cfg_nout weight rows into a serial
// inner-product PE, one element per cycle, and returns each PE result on a
// valid/ready stream tagged with its output-neuron index.
//   clk, rst                : clock, asynchronous active-high reset
//   start, cfg_*            : job launch and configuration (sampled on accept)
//   busy, done              : job status; done pulses once per job
//   nbuf_* / wbuf_*         : neuron / weight buffer read ports (1-cycle latency)
//   pe_neuron, pe_weight    : element operands to the PE (buffer pass-through)
//   pe_ctrl, pe_vld         : element framing {last, first} and valid
//   pe_result, pe_vld_o     : PE result and its valid
//   out_valid/ready/data/idx: result stream
// ---------------------------------------------------------------------------
module pe_vector_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 32,
    parameter int NAW   = 10,
    parameter int WAW   = 14,
    parameter int LEN_W = 10,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_vlen,
    input  logic [IDX_W-1:0] cfg_nout,
    input  logic [NAW-1:0]   cfg_nbase,
    input  logic [WAW-1:0]   cfg_wbase,
    output logic             busy,
    output logic             done,
    output logic             nbuf_rd_en,
    output logic [NAW-1:0]   nbuf_addr,
    input  logic [DW-1:0]    nbuf_rdata,
    output logic             wbuf_rd_en,
    output logic [WAW-1:0]   wbuf_addr,
    input  logic [DW-1:0]    wbuf_rdata,
    output logic [DW-1:0]    pe_neuron,
    output logic [DW-1:0]    pe_weight,
    output logic [1:0]       pe_ctrl,
    output logic             pe_vld,
    input  logic [ACC_W-1:0] pe_result,
    input  logic             pe_vld_o,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [IDX_W-1:0] out_idx
);

    state_t           state_q,    state_d;
    logic [LEN_W-1:0] vlen_q,     vlen_d;
    logic [IDX_W-1:0] nout_q,     nout_d;
    logic [NAW-1:0]   nbase_q,    nbase_d;
    logic [LEN_W-1:0] k_q,        k_d;        // element index within the row
    logic [IDX_W-1:0] j_q,        j_d;        // row index being issued
    logic [NAW-1:0]   naddr_q,    naddr_d;
    logic [WAW-1:0]   waddr_q,    waddr_d;    // runs across rows: rows are contiguous
    logic [1:0]       inflight_q, inflight_d; // rows started but not yet returned by the PE
    logic [IDX_W-1:0] ridx_q,     ridx_d;     // index given to the next captured result
    logic             pe_vld_q,   pe_vld_d;
    logic [1:0]       pe_ctrl_q,  pe_ctrl_d;
    logic             busy_q,     busy_d;
    logic             done_q,     done_d;

    logic [1:0] fifo_count;
    logic       row_start;
    logic       last_elem;
    logic       last_row;
    logic       issue;
    logic       pe_push;

    assign row_start = (k_q == '0);
    assign last_elem = (k_q == vlen_q - LEN_W'(1));
    assign last_row  = (j_q == nout_q - IDX_W'(1));

    // Only the first element of a row waits for a credit; once a row has
    // begun it streams to completion without gaps.
    assign issue = (state_q == RUN) && (!row_start || credit_ok(fifo_count, inflight_q));

    // Results are only accepted for rows this job actually started, so a PE
    // result still emerging after a reset cannot leak into the FIFO.
    assign pe_push = pe_vld_o && (inflight_q != 2'd0);

    always_comb begin
        state_d    = state_q;
        vlen_d     = vlen_q;
        nout_d     = nout_q;
        nbase_d    = nbase_q;
        k_d        = k_q;
        j_d        = j_q;
        naddr_d    = naddr_q;
        waddr_d    = waddr_q;
        inflight_d = inflight_q + 2'(issue && row_start) - 2'(pe_push);
        ridx_d     = pe_push ? (ridx_q + IDX_W'(1)) : ridx_q;
        pe_vld_d   = issue;
        pe_ctrl_d  = 2'b00;
        if (issue) begin
            pe_ctrl_d[CTRL_FIRST] = row_start;
            pe_ctrl_d[CTRL_LAST]  = last_elem;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    vlen_d  = cfg_vlen;
                    nout_d  = cfg_nout;
                    nbase_d = cfg_nbase;
                    naddr_d = cfg_nbase;
                    waddr_d = cfg_wbase;
                    k_d     = '0;
                    j_d     = '0;
                    ridx_d  = '0;
                    state_d = ((cfg_vlen == '0) || (cfg_nout == '0)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (issue) begin
                    waddr_d = waddr_q + WAW'(1);
                    if (last_elem) begin
                        k_d     = '0;
                        j_d     = j_q + IDX_W'(1);
                        naddr_d = nbase_q;
                        if (last_row) begin
                            state_d = DRAIN;
                        end
                    end else begin
                        k_d     = k_q + LEN_W'(1);
                        naddr_d = naddr_q + NAW'(1);
                    end
                end
            end
            DRAIN: begin
                if ((fifo_count == 2'd0) && (inflight_q == 2'd0)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // busy follows the next state; done is taken from the DONE state one
        // cycle later, so busy falls exactly as done pulses.
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vlen_q     <= '0;
            nout_q     <= '0;
            nbase_q    <= '0;
            k_q        <= '0;
            j_q        <= '0;
            naddr_q    <= '0;
            waddr_q    <= '0;
            inflight_q <= 2'd0;
            ridx_q     <= '0;
            pe_vld_q   <= 1'b0;
            pe_ctrl_q  <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vlen_q     <= vlen_d;
            nout_q     <= nout_d;
            nbase_q    <= nbase_d;
            k_q        <= k_d;
            j_q        <= j_d;
            naddr_q    <= naddr_d;
            waddr_q    <= waddr_d;
            inflight_q <= inflight_d;
            ridx_q     <= ridx_d;
            pe_vld_q   <= pe_vld_d;
            pe_ctrl_q  <= pe_ctrl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    pe_result_fifo #(
        .ACC_W (ACC_W),
        .IDX_W (IDX_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (pe_push),
        .push_data (pe_result),
        .push_idx  (ridx_q),
        .pop_valid (out_valid),
        .pop_ready (out_ready),
        .pop_data  (out_data),
        .pop_idx   (out_idx),
        .count     (fifo_count)
    );

    // Read data arrives one cycle after issue, aligned with pe_vld.
    assign nbuf_rd_en = issue;
    assign wbuf_rd_en = issue;
    assign nbuf_addr  = naddr_q;
    assign wbuf_addr  = waddr_q;
    assign pe_neuron  = nbuf_rdata;
    assign pe_weight  = wbuf_rdata;
    assign pe_vld     = pe_vld_q;
    assign pe_ctrl    = pe_ctrl_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pe_vector_feeder.sv
// ---------------------------------------------------------------------------
// tb_pe_vector_feeder
// Directed bench: behavioural neuron/weight buffers with one-cycle read
// latency and a serial multiply-accumulate PE model drive the feeder; each
// task applies one scenario and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_pe_vector_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  cfg_vlen;
    logic [9:0]  cfg_nout;
    logic [9:0]  cfg_nbase;
    logic [13:0] cfg_wbase;
    logic        busy, done;
    logic        nbuf_rd_en, wbuf_rd_en;
    logic [9:0]  nbuf_addr;
    logic [13:0] wbuf_addr;
    logic [15:0] nbuf_rdata, wbuf_rdata;
    logic [15:0] pe_neuron, pe_weight;
    logic [1:0]  pe_ctrl;
    logic        pe_vld;
    logic [31:0] pe_result;
    logic        pe_vld_o;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic [9:0]  out_idx;

    int checks = 0;
    int errors = 0;

    pe_vector_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cfg_vlen   (cfg_vlen),
        .cfg_nout   (cfg_nout),
        .cfg_nbase  (cfg_nbase),
        .cfg_wbase  (cfg_wbase),
        .busy       (busy),
        .done       (done),
        .nbuf_rd_en (nbuf_rd_en),
        .nbuf_addr  (nbuf_addr),
        .nbuf_rdata (nbuf_rdata),
        .wbuf_rd_en (wbuf_rd_en),
        .wbuf_addr  (wbuf_addr),
        .wbuf_rdata (wbuf_rdata),
        .pe_neuron  (pe_neuron),
        .pe_weight  (pe_weight),
        .pe_ctrl    (pe_ctrl),
        .pe_vld     (pe_vld),
        .pe_result  (pe_result),
        .pe_vld_o   (pe_vld_o),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx)
    );

    always #5 clk = ~clk;

    // Buffers with one-cycle registered read.
    logic [15:0] nmem [1024];
    logic [15:0] wmem [16384];
    always @(posedge clk) begin
        if (nbuf_rd_en) nbuf_rdata <= nmem[nbuf_addr];
        if (wbuf_rd_en) wbuf_rdata <= wmem[wbuf_addr];
    end

    // Serial inner-product PE: result valid the cycle after the last element.
    logic signed [31:0] acc, prod, sum_next;
    assign prod     = $signed(pe_neuron) * $signed(pe_weight);
    assign sum_next = (pe_ctrl[0] ? 32'sd0 : acc) + prod;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= 32'sd0;
            pe_result <= 32'd0;
            pe_vld_o  <= 1'b0;
        end else begin
            pe_vld_o <= 1'b0;
            if (pe_vld) begin
                acc <= sum_next;
                if (pe_ctrl[1]) begin
                    pe_result <= sum_next;
                    pe_vld_o  <= 1'b1;
                end
            end
        end
    end

    // Observation logs, sampled on the falling edge.
    int          cyc = 0;
    logic [1:0]  ctrl_log [$];
    logic [13:0] waddr_log [$];
    logic [15:0] neu_log [$];
    logic [15:0] wgt_log [$];
    logic [31:0] res_data [$];
    logic [9:0]  res_idx [$];
    int rd_cnt, vld_cnt, done_cnt, ctrl_idle_bad, last_issue_cyc, first_ov_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wbuf_rd_en) begin
            waddr_log.push_back(wbuf_addr);
            last_issue_cyc = cyc;
        end
        if (nbuf_rd_en || wbuf_rd_en) rd_cnt++;
        if (pe_vld) begin
            ctrl_log.push_back(pe_ctrl);
            neu_log.push_back(pe_neuron);
            wgt_log.push_back(pe_weight);
            vld_cnt++;
        end else if (pe_ctrl !== 2'b00) begin
            ctrl_idle_bad++;
        end
        if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
        if (out_valid && out_ready) begin
            res_data.push_back(out_data);
            res_idx.push_back(out_idx);
            $display("result idx=%0d data=%0d (0x%08h)", out_idx, $signed(out_data), out_data);
        end
        if (done) done_cnt++;
    end

    task automatic clear_logs();
        ctrl_log.delete(); waddr_log.delete(); neu_log.delete(); wgt_log.delete();
        res_data.delete(); res_idx.delete();
        rd_cnt = 0; vld_cnt = 0; done_cnt = 0; ctrl_idle_bad = 0;
        last_issue_cyc = -1; first_ov_cyc = -1;
    endtask

    // Called just after a rising edge; leaves just after the accepting edge.
    task automatic do_start(input logic [9:0] vl, input logic [9:0] no,
                            input logic [9:0] nb, input logic [13:0] wb);
        cfg_vlen = vl; cfg_nout = no; cfg_nbase = nb; cfg_wbase = wb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        $display("start vlen=%0d nout=%0d nbase=%0d wbase=%0d", vl, no, nb, wb);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld, out_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b expected 000000",
                     {busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld, out_valid});
        end
        checks++;
        if (pe_ctrl !== 2'b00) begin
            errors++;
            $display("FAIL reset_pe_ctrl: got %b expected 00", pe_ctrl);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (nbuf_addr !== 10'd0 || wbuf_addr !== 14'd0) begin
            errors++;
            $display("FAIL reset_addr: got n=%0d w=%0d expected 0 0", nbuf_addr, wbuf_addr);
        end
        checks++;
        if (out_data !== 32'd0 || out_idx !== 10'd0) begin
            errors++;
            $display("FAIL reset_out: got data=%0d idx=%0d expected 0 0", out_data, out_idx);
        end
    endtask

    task automatic test_basic();
        bit ok;
        logic [1:0] exp_ctrl [4];
        exp_ctrl[0] = 2'b01; exp_ctrl[1] = 2'b00; exp_ctrl[2] = 2'b00; exp_ctrl[3] = 2'b10;
        clear_logs();
        out_ready = 1'b1;
        do_start(10'd4, 10'd1, 10'd10, 14'd100);
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_done: got timeout expected done"); end
        checks++;
        if (ctrl_log.size() != 4) begin
            errors++;
            $display("FAIL basic_ctrl_count: got %0d expected 4", ctrl_log.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ctrl_log[i] !== exp_ctrl[i]) begin
                errors++;
                $display("FAIL basic_ctrl[%0d]: got %b expected %b", i, ctrl_log[i], exp_ctrl[i]);
            end
            checks++;
            if (waddr_log[i] !== 14'(100 + i)) begin
                errors++;
                $display("FAIL basic_waddr[%0d]: got %0d expected %0d", i, waddr_log[i], 100 + i);
            end
        end
        checks++;
        if (res_data.size() != 1 || res_data[0] !== 32'd70 || res_idx[0] !== 10'd0) begin
            errors++;
            $display("FAIL basic_result: got n=%0d data=%0d idx=%0d expected n=1 data=70 idx=0",
                     res_data.size(), res_data[0], res_idx[0]);
        end
        checks++;
        if (first_ov_cyc - last_issue_cyc != 3) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 3", first_ov_cyc - last_issue_cyc);
        end
        checks++;
        if (done_cnt != 1 || ctrl_idle_bad != 0) begin
            errors++;
            $display("FAIL basic_done_idle: got done=%0d idle_ctrl=%0d expected 1 0",
                     done_cnt, ctrl_idle_bad);
        end
    endtask

    task automatic test_vlen1();
        bit ok;
        logic [31:0] exp_res [3];
        exp_res[0] = 32'd21; exp_res[1] = 32'hFFFF_FFE4; exp_res[2] = 32'd35;
        clear_logs();
        do_start(10'd1, 10'd3, 10'd20, 14'd200);
        wait_done(200, ok);
        checks++;
        if (!ok || res_data.size() != 3) begin
            errors++;
            $display("FAIL vlen1_done: got ok=%0d n=%0d expected 1 3", ok, res_data.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ctrl_log[i] !== 2'b11 || waddr_log[i] !== 14'(200 + i)) begin
                errors++;
                $display("FAIL vlen1_issue[%0d]: got ctrl=%b waddr=%0d expected 11 %0d",
                         i, ctrl_log[i], waddr_log[i], 200 + i);
            end
            checks++;
            if (res_data[i] !== exp_res[i] || res_idx[i] !== 10'(i)) begin
                errors++;
                $display("FAIL vlen1_result[%0d]: got data=%0d idx=%0d expected %0d %0d",
                         i, $signed(res_data[i]), res_idx[i], $signed(exp_res[i]), i);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [31:0] exp_res [4];
        exp_res[0] = 32'd14; exp_res[1] = 32'd32; exp_res[2] = 32'd50; exp_res[3] = 32'd68;
        clear_logs();
        out_ready = 1'b0;
        do_start(10'd3, 10'd4, 10'd30, 14'd300);
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (vld_cnt != 6 || rd_cnt != 6) begin
            errors++;
            $display("FAIL stall_issue: got vld=%0d rd=%0d expected 6 6", vld_cnt, rd_cnt);
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'd14 || out_idx !== 10'd0) begin
            errors++;
            $display("FAIL stall_hold: got v=%b data=%0d idx=%0d expected 1 14 0",
                     out_valid, out_data, out_idx);
        end
        out_ready = 1'b1;
        wait_done(300, ok);
        checks++;
        if (!ok || res_data.size() != 4 || vld_cnt != 12) begin
            errors++;
            $display("FAIL stall_drain: got ok=%0d n=%0d vld=%0d expected 1 4 12",
                     ok, res_data.size(), vld_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (res_data[i] !== exp_res[i] || res_idx[i] !== 10'(i)) begin
                errors++;
                $display("FAIL stall_result[%0d]: got data=%0d idx=%0d expected %0d %0d",
                         i, res_data[i], res_idx[i], exp_res[i], i);
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        clear_logs();
        do_start(10'd2, 10'd1, 10'd40, 14'd400);
        wait_done(200, ok);
        checks++;
        if (!ok || res_data.size() != 1 || res_data[0] !== 32'h8000_0000) begin
            errors++;
            $display("FAIL overflow_result: got ok=%0d n=%0d data=0x%08h expected 1 1 0x80000000",
                     ok, res_data.size(), res_data[0]);
        end
        checks++;
        if (neu_log[0] !== 16'h8000 || wgt_log[1] !== 16'h8000) begin
            errors++;
            $display("FAIL overflow_passthru: got n=0x%04h w=0x%04h expected 0x8000 0x8000",
                     neu_log[0], wgt_log[1]);
        end
    endtask

    task automatic test_zero();
        logic [9:0] vl [2];
        logic [9:0] no [2];
        int done_at;
        vl[0] = 10'd0; no[0] = 10'd3;
        vl[1] = 10'd3; no[1] = 10'd0;
        for (int c = 0; c < 2; c++) begin
            clear_logs();
            cfg_vlen = vl[c]; cfg_nout = no[c]; cfg_nbase = 10'd5; cfg_wbase = 14'd5;
            start = 1'b1;
            done_at = -1;
            for (int n = 1; n <= 6; n++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (done && done_at < 0) done_at = n;
            end
            $display("zero job vlen=%0d nout=%0d done_at=%0d", vl[c], no[c], done_at);
            checks++;
            if (done_at != 2) begin
                errors++;
                $display("FAIL zero_done[%0d]: got %0d expected 2", c, done_at);
            end
            checks++;
            if (rd_cnt != 0 || vld_cnt != 0) begin
                errors++;
                $display("FAIL zero_traffic[%0d]: got rd=%0d vld=%0d expected 0 0",
                         c, rd_cnt, vld_cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit hit;
        clear_logs();
        out_ready = 1'b1;
        do_start(10'd4, 10'd5, 10'd10, 14'd500);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wbuf_rd_en && wbuf_addr == 14'd509) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midrst_reach: got timeout expected row 2"); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld, out_valid, pe_ctrl} !== 8'b0) begin
            errors++;
            $display("FAIL midrst_ctl: got %b expected 00000000",
                     {busy, done, nbuf_rd_en, wbuf_rd_en, pe_vld, out_valid, pe_ctrl});
        end
        checks++;
        if (nbuf_addr !== 10'd0 || wbuf_addr !== 14'd0 || out_data !== 32'd0 || out_idx !== 10'd0) begin
            errors++;
            $display("FAIL midrst_data: got n=%0d w=%0d d=%0d i=%0d expected 0 0 0 0",
                     nbuf_addr, wbuf_addr, out_data, out_idx);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        clear_logs();
        do_start(10'd2, 10'd2, 10'd10, 14'd100);
        wait_done(200, ok);
        checks++;
        if (!ok || res_data.size() != 2) begin
            errors++;
            $display("FAIL midrst_rerun: got ok=%0d n=%0d expected 1 2", ok, res_data.size());
        end
        checks++;
        if (res_data[0] !== 32'd17 || res_idx[0] !== 10'd0 ||
            res_data[1] !== 32'd23 || res_idx[1] !== 10'd1) begin
            errors++;
            $display("FAIL midrst_results: got %0d/%0d %0d/%0d expected 17/0 23/1",
                     res_data[0], res_idx[0], res_data[1], res_idx[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) nmem[i] = 16'd0;
        for (int i = 0; i < 16384; i++) wmem[i] = 16'd0;
        // basic: n = {1,2,3,4} at 10, w = {5,6,7,8} at 100
        for (int i = 0; i < 4; i++) begin
            nmem[10 + i]  = 16'(i + 1);
            wmem[100 + i] = 16'(i + 5);
        end
        // vlen=1: n = 7, weights 3, -4, 5
        nmem[20]  = 16'd7;
        wmem[200] = 16'd3;
        wmem[201] = 16'hFFFC;
        wmem[202] = 16'd5;
        // backpressure: n = {1,2,3}, weights 1..12 row-major
        for (int i = 0; i < 3; i++) nmem[30 + i] = 16'(i + 1);
        for (int i = 0; i < 12; i++) wmem[300 + i] = 16'(i + 1);
        // extreme operands
        nmem[40]  = 16'h8000; nmem[41]  = 16'h8000;
        wmem[400] = 16'h8000; wmem[401] = 16'h8000;

        start = 1'b0;
        out_ready = 1'b1;
        cfg_vlen = '0; cfg_nout = '0; cfg_nbase = '0; cfg_wbase = '0;
        clear_logs();

        test_reset();
        test_basic();
        test_vlen1();
        test_back_to_back();
        test_overflow();
        test_zero();
        test_reset_mid();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
